// File: rtl/cpu_pkg.sv
// Shared operation encoding for the program counter / return-address stack.
// The priority order of simultaneous commands lives in sel_op below.
package cpu_pkg;

    typedef enum logic [2:0] {
        OP_HOLD  = 3'd0,
        OP_INC   = 3'd1,
        OP_REL   = 3'd2,
        OP_LOAD  = 3'd3,
        OP_CALL  = 3'd4,
        OP_RET   = 3'd5,
        OP_STALL = 3'd6
    } op_e;

    // stall > ret > call > pcload > pcrel > pcinc > hold
    function automatic op_e sel_op(input logic stall, input logic ret, input logic call,
                                   input logic pcload, input logic pcrel, input logic pcinc);
        if (stall)       return OP_STALL;
        else if (ret)    return OP_RET;
        else if (call)   return OP_CALL;
        else if (pcload) return OP_LOAD;
        else if (pcrel)  return OP_REL;
        else if (pcinc)  return OP_INC;
        else             return OP_HOLD;
    endfunction

endpackage

// File: rtl/pc_ras_stack.sv
// LIFO storage and occupancy counter for return addresses.
// The caller guarantees push only when not full and pop only when not empty.
module pc_ras_stack #(
    parameter int AW    = 16,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [AW-1:0]                push_data,
    output logic [AW-1:0]                top,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);
    localparam int LW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);

    logic [AW-1:0] mem [DEPTH];
    logic [LW-1:0] cnt;
    logic [LW-1:0] top_idx;

    // Storage is deliberately left without reset; it is unobservable at level 0.
    always_ff @(posedge clk) begin
        if (push) mem[cnt[IW-1:0]] <= push_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      cnt <= '0;
        else if (push) cnt <= cnt + LW'(1);
        else if (pop)  cnt <= cnt - LW'(1);
    end

    assign top_idx = cnt - LW'(1);
    assign top     = mem[top_idx[IW-1:0]];
    assign level   = cnt;
    assign full    = (cnt == LW'(DEPTH));
    assign empty   = (cnt == '0);

endmodule

// File: rtl/pc_ras.sv
// Program counter with call/return stack and sticky overflow/underflow flags.
// dout, error flags and operation selection live here; the LIFO is pc_ras_stack.
module pc_ras
    import cpu_pkg::*;
#(
    parameter int            AW      = 16,
    parameter int            DEPTH   = 8,
    parameter logic [AW-1:0] RST_VEC = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [AW-1:0]                din,
    input  logic                         pcload,
    input  logic                         pcinc,
    input  logic                         pcrel,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         stall,
    input  logic                         clr_err,
    output logic [AW-1:0]                dout,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty,
    output logic                         ovf_err,
    output logic                         unf_err
);
    op_e           op;
    logic          push;
    logic          pop;
    logic [AW-1:0] top;

    assign op   = sel_op(stall, ret, call, pcload, pcrel, pcinc);
    assign push = (op == OP_CALL) && !full;
    assign pop  = (op == OP_RET)  && !empty;

    pc_ras_stack #(.AW(AW), .DEPTH(DEPTH)) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (dout + AW'(1)),
        .top       (top),
        .level     (level),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout    <= RST_VEC;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            // Clear first so that an error set later in this cycle wins.
            if (op != OP_STALL && clr_err) begin
                ovf_err <= 1'b0;
                unf_err <= 1'b0;
            end
            case (op)
                OP_RET:  if (empty) unf_err <= 1'b1; else dout <= top;
                OP_CALL: if (full)  ovf_err <= 1'b1; else dout <= din;
                OP_LOAD: dout <= din;
                OP_REL:  dout <= dout + din;
                OP_INC:  dout <= dout + AW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: doc/pc_ras.md
PC_RAS -- requirements
Module: pc_ras

Interface
REQ-001 SHALL have parameter AW, default 16, program counter and address width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, return-address stack entries (DEPTH >= 2).
REQ-003 SHALL have parameter RST_VEC, default 0, value loaded into dout on reset.
REQ-004 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have din  input  AW  jump target, or two's-complement offset when pcrel=1.
REQ-007 SHALL have pcload  input  1  absolute load, dout <= din.
REQ-008 SHALL have pcinc  input  1  dout <= dout + 1.
REQ-009 SHALL have pcrel  input  1  dout <= dout + din.
REQ-010 SHALL have call  input  1  push dout+1 onto the stack and set dout <= din.
REQ-011 SHALL have ret  input  1  pop the stack top into dout.
REQ-012 SHALL have stall  input  1  hold all state.
REQ-013 SHALL have clr_err  input  1  clear the sticky error flags.
REQ-014 SHALL have dout  output  AW  current instruction address, registered.
REQ-015 SHALL have level  output  $clog2(DEPTH+1)  current stack occupancy.
REQ-016 SHALL have full, empty  output  1 each  level==DEPTH and level==0 respectively.
REQ-017 SHALL have ovf_err, unf_err  output  1 each  sticky overflow and underflow flags.

Function
REQ-018 SHALL apply exactly one operation per cycle, in this priority: stall > ret > call > pcload > pcrel > pcinc > hold.
REQ-019 SHALL make every operation take effect on the next rising edge; dout is updated one cycle after the command, with no combinational path from inputs to dout.
REQ-020 SHALL compute all arithmetic modulo 2^AW; dout = all-ones with pcinc yields 0, and pcrel wraps without a flag.
REQ-021 SHALL treat din as signed under pcrel, so that din = all-ones decrements dout by 1.
REQ-022 On call when not full, SHALL write (dout+1) mod 2^AW at index level, increment level and load din into dout.
REQ-023 On call when full, SHALL leave dout, the stack and level unchanged and set ovf_err.
REQ-024 On ret when not empty, SHALL load the entry at index level-1 into dout and decrement level.
REQ-025 On ret when empty, SHALL leave dout and level unchanged and set unf_err.
REQ-026 When call and ret are asserted together, SHALL execute ret only; the call is discarded and no error is flagged.
REQ-027 SHALL clear both error flags on clr_err; if an error event occurs in the same cycle, the set wins.
REQ-028 When stall is asserted, SHALL hold dout, the stack, level and the error flags; clr_err is also ignored while stalled.
REQ-029 SHALL drive full, empty and level from registered state only.

Reset
REQ-030 On rst=0, SHALL immediately set dout=RST_VEC, level=0, empty=1, full=0 and ovf_err=unf_err=0, regardless of clk.
REQ-031 SHALL leave the stack storage contents uninitialised; they are unobservable while level=0.
REQ-032 When reset is asserted mid-operation, SHALL abandon any pending command; the first command executes on the first rising edge after rst returns to 1.

Structure
REQ-033 SHALL place the operation priority encoding constants in the shared package cpu_pkg.
REQ-034 SHALL implement the LIFO storage and level counter as sub-module pc_ras_stack, parametrised by AW and DEPTH, with push/pop inputs and top/full/empty outputs.
REQ-035 SHALL keep the dout register, operation selection and error flags in pc_ras.

Verification
REQ-036 Reset then 3x pcinc -> dout=3; rst low mid-cycle -> dout=RST_VEC immediately, level=0.
REQ-037 dout=0xFFFF, pcinc -> dout=0x0000; dout=0x0010, pcrel with din=0xFFF0 -> dout=0x0000.
REQ-038 dout=0x0100, call din=0x2000 -> dout=0x2000, level=1; ret -> dout=0x0101, level=0.
REQ-039 DEPTH=8: 8 calls -> full=1; 9th call -> dout unchanged, level=8, ovf_err=1; clr_err -> ovf_err=0.
REQ-040 Empty stack: ret -> unf_err=1, dout unchanged; call+ret together with level=2 -> ret only, level=1.
REQ-041 stall together with call -> no change to dout or level; pcload+pcinc together -> dout=din.
